// File: rtl/display_scan_controller_pkg.sv
// Shared constants and the digit-to-segment lookup for the display scan controller.
package display_scan_controller_pkg;

  localparam int DISPLAY_DIGITS = 8;

  typedef logic [3:0] digit_code_t;
  typedef logic [6:0] segments_t;

  localparam digit_code_t DIGIT_DASH  = 4'hc;
  localparam digit_code_t DIGIT_BLANK = 4'hf;

  localparam segments_t SEG_0     = 7'h3f;
  localparam segments_t SEG_1     = 7'h06;
  localparam segments_t SEG_2     = 7'h5b;
  localparam segments_t SEG_3     = 7'h4f;
  localparam segments_t SEG_4     = 7'h66;
  localparam segments_t SEG_5     = 7'h6d;
  localparam segments_t SEG_6     = 7'h7d;
  localparam segments_t SEG_7     = 7'h07;
  localparam segments_t SEG_8     = 7'h7f;
  localparam segments_t SEG_9     = 7'h6f;
  localparam segments_t SEG_A     = 7'h77;
  localparam segments_t SEG_B     = 7'h7c;
  localparam segments_t SEG_DASH  = 7'h40;
  localparam segments_t SEG_D     = 7'h5e;
  localparam segments_t SEG_E     = 7'h79;
  localparam segments_t SEG_BLANK = 7'h00;

  // Segment a is bit 0; codes C and F are repurposed as dash and blank.
  function automatic segments_t seg_lookup(input digit_code_t code);
    case (code)
      4'h0:        return SEG_0;
      4'h1:        return SEG_1;
      4'h2:        return SEG_2;
      4'h3:        return SEG_3;
      4'h4:        return SEG_4;
      4'h5:        return SEG_5;
      4'h6:        return SEG_6;
      4'h7:        return SEG_7;
      4'h8:        return SEG_8;
      4'h9:        return SEG_9;
      4'ha:        return SEG_A;
      4'hb:        return SEG_B;
      DIGIT_DASH:  return SEG_DASH;
      4'hd:        return SEG_D;
      4'he:        return SEG_E;
      default:     return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Display-side bus: display words and overlay request in, scan outputs back.
interface display_scan_controller_if;
  logic [31:0] numbers;
  logic [7:0]  blink_mask;
  logic        overlay_req;
  logic [31:0] overlay_numbers;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic        frame_done;
  logic        overlay_active;

  modport master (
    output numbers, blink_mask, overlay_req, overlay_numbers,
    input  seg_en, seg_out, frame_done, overlay_active
  );

  modport slave (
    input  numbers, blink_mask, overlay_req, overlay_numbers,
    output seg_en, seg_out, frame_done, overlay_active
  );
endinterface

// File: rtl/display_scan_controller_seg_decoder.sv
// Combinational 4-bit digit code to 7-segment pattern decoder.
module display_scan_controller_seg_decoder
  import display_scan_controller_pkg::*;
(
  input  digit_code_t code,
  output segments_t   segments
);

  always_comb begin
    segments = seg_lookup(code);
  end

endmodule

// File: rtl/display_scan_controller.sv
// 8-digit 7-segment scan controller with frame-synchronous snapshot, blinking and timed overlay.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLINK_FRAMES   = 62,
  parameter int OVERLAY_FRAMES = 250
) (
  input logic                       clk,
  input logic                       rst,
  display_scan_controller_if.slave  bus
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PRE_W    = $clog2(SCAN_DIV);
  localparam int BLINK_W  = $clog2(BLINK_FRAMES + 1);
  localparam int OV_W     = $clog2(OVERLAY_FRAMES + 1);

  logic [PRE_W-1:0]   prescaler_reg;
  logic [2:0]         index_reg;
  logic [31:0]        frame_word_reg;
  logic [7:0]         frame_mask_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;
  logic [OV_W-1:0]    ov_cnt_reg;
  logic [31:0]        ov_buf_reg;
  logic [7:0]         seg_en_reg;
  logic [7:0]         seg_out_reg;
  logic               frame_done_reg;
  logic               overlay_active_reg;

  logic        tick;
  logic        boundary;
  digit_code_t digit_nibbles [DISPLAY_DIGITS];
  digit_code_t cur_nibble;
  segments_t   cur_segments;

  assign tick     = (prescaler_reg == PRE_W'(SCAN_DIV - 1));
  assign boundary = tick && (index_reg == 3'd7);

  genvar gi;
  generate
    for (gi = 0; gi < DISPLAY_DIGITS; gi++) begin : g_nibble
      assign digit_nibbles[gi] = frame_word_reg[4*gi +: 4];
    end
  endgenerate

  assign cur_nibble = digit_nibbles[index_reg];

  display_scan_controller_seg_decoder u_seg_decoder (
    .code     (cur_nibble),
    .segments (cur_segments)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_reg      <= '0;
      index_reg          <= '0;
      frame_word_reg     <= 32'hffffffff;
      frame_mask_reg     <= '0;
      blink_cnt_reg      <= '0;
      blink_phase_reg    <= 1'b0;
      ov_cnt_reg         <= '0;
      ov_buf_reg         <= '0;
      seg_en_reg         <= '0;
      seg_out_reg        <= '0;
      frame_done_reg     <= 1'b0;
      overlay_active_reg <= 1'b0;
    end else begin
      prescaler_reg <= tick ? '0 : prescaler_reg + PRE_W'(1);
      if (tick) begin
        index_reg <= index_reg + 3'd1;
      end

      // Snapshot at the frame boundary so a digit never changes mid-frame.
      if (boundary) begin
        frame_word_reg <= (ov_cnt_reg != '0) ? ov_buf_reg : bus.numbers;
        frame_mask_reg <= bus.blink_mask;
        if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        end
      end

      // A fresh request wins over the boundary decrement, restarting the full count.
      if (bus.overlay_req) begin
        ov_buf_reg <= bus.overlay_numbers;
        ov_cnt_reg <= OV_W'(OVERLAY_FRAMES);
      end else if (boundary && (ov_cnt_reg != '0)) begin
        ov_cnt_reg <= ov_cnt_reg - OV_W'(1);
      end

      seg_en_reg         <= 8'b1 << index_reg;
      seg_out_reg        <= (frame_mask_reg[index_reg] && blink_phase_reg) ? 8'h00
                                                                           : {1'b0, cur_segments};
      frame_done_reg     <= boundary;
      overlay_active_reg <= (ov_cnt_reg != '0);
    end
  end

  assign bus.seg_en         = seg_en_reg;
  assign bus.seg_out        = seg_out_reg;
  assign bus.frame_done     = frame_done_reg;
  assign bus.overlay_active = overlay_active_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller: per-cycle expected outputs plus per-frame digit checks.
module tb_display_scan_controller;

  localparam int CLK_HZ         = 80;
  localparam int SCAN_HZ        = 10;
  localparam int BLINK_FRAMES   = 2;
  localparam int OVERLAY_FRAMES = 3;
  localparam int SCAN_DIV       = CLK_HZ / SCAN_HZ;
  localparam int FRAME          = SCAN_DIV * 8;

  logic clk = 1'b0;
  logic rst;

  display_scan_controller_if bus ();

  display_scan_controller #(
    .CLK_HZ         (CLK_HZ),
    .SCAN_HZ        (SCAN_HZ),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .OVERLAY_FRAMES (OVERLAY_FRAMES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] seg;
    logic       fd;
    logic       ov;
  } exp_t;

  exp_t exp_q [$];

  logic [7:0] seg_ref [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                               8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h40, 8'h5e, 8'h79, 8'h00};

  int n_checks = 0;
  int n_pass   = 0;
  int frame_no = 0;

  // Reference model state
  int          m_cyc;
  logic [31:0] m_word;
  logic [7:0]  m_mask;
  int          m_bounds;
  int          m_ov;
  logic [31:0] m_ovbuf;

  logic [7:0] cap [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: push the expected post-edge outputs, advance the model, clock, then compare.
  task automatic step();
    exp_t e;
    exp_t got;
    int idx;
    logic [3:0] nib;
    logic boundary;
    e = '0;
    if (rst) begin
      m_cyc = 0; m_word = 32'hffffffff; m_mask = 8'h00;
      m_bounds = 0; m_ov = 0; m_ovbuf = 32'h0;
    end else begin
      idx      = (m_cyc / SCAN_DIV) % 8;
      nib      = m_word[4*idx +: 4];
      boundary = ((m_cyc % FRAME) == FRAME - 1);
      e.en  = 8'h01 << idx;
      e.seg = (m_mask[idx] && (((m_bounds / BLINK_FRAMES) % 2) == 1)) ? 8'h00 : seg_ref[nib];
      e.fd  = boundary;
      e.ov  = (m_ov != 0);
      if (boundary) begin
        m_word = (m_ov != 0) ? m_ovbuf : bus.numbers;
        m_mask = bus.blink_mask;
        m_bounds++;
      end
      if (bus.overlay_req) begin
        m_ov = OVERLAY_FRAMES;
        m_ovbuf = bus.overlay_numbers;
      end else if (boundary && m_ov != 0) begin
        m_ov--;
      end
      m_cyc++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got.en  = bus.seg_en;
    got.seg = bus.seg_out;
    got.fd  = bus.frame_done;
    got.ov  = bus.overlay_active;
    e = exp_q.pop_front();
    check_eq("seg_en", got.en, e.en);
    check_eq("seg_out", got.seg, e.seg);
    check_eq("frame_done", got.fd, e.fd);
    check_eq("overlay_active", got.ov, e.ov);
  endtask

  // Step until frame_done is seen (bounded); reports step count and any lit segment.
  task automatic sync_boundary(output int n, output logic lit);
    logic found;
    found = 1'b0;
    lit = 1'b0;
    n = 0;
    while (!found && n < 4 * FRAME) begin
      step();
      n++;
      if (bus.seg_out != 8'h00) lit = 1'b1;
      if (bus.frame_done) found = 1'b1;
    end
    check_eq("boundary_found", found, 1'b1);
  endtask

  // One full frame starting just after a boundary; optional overlay request / numbers change.
  task automatic run_frame(input int req_at, input logic [31:0] req_word,
                           input int num_at, input logic [31:0] num_word);
    for (int j = 0; j < FRAME; j++) begin
      if (j == num_at) bus.numbers = num_word;
      bus.overlay_req = (j == req_at);
      if (j == req_at) bus.overlay_numbers = req_word;
      step();
      for (int d = 0; d < 8; d++)
        if (bus.seg_en == (8'h01 << d)) cap[d] = bus.seg_out;
    end
    bus.overlay_req = 1'b0;
    frame_no++;
    $display("frame %0d: seg d7..d0 = %h %h %h %h %h %h %h %h ov=%0b",
             frame_no, cap[7], cap[6], cap[5], cap[4], cap[3], cap[2], cap[1], cap[0],
             bus.overlay_active);
  endtask

  int n_steps;
  logic lit;
  int blank_frames;
  logic other_blank;
  logic [7:0] s5_exp [7] = '{8'h06, 8'h5b, 8'h5b, 8'h4f, 8'h4f, 8'h4f, 8'h3f};
  logic [7:0] s1_exp [8] = '{8'h7d, 8'h6d, 8'h40, 8'h66, 8'h4f, 8'h40, 8'h5b, 8'h06};

  initial begin
    bus.numbers = 32'h0;
    bus.blink_mask = 8'h00;
    bus.overlay_req = 1'b0;
    bus.overlay_numbers = 32'h0;
    rst = 1'b1;
    step();
    step();
    check_eq("rst_seg_en", bus.seg_en, 8'h00);
    check_eq("rst_seg_out", bus.seg_out, 8'h00);
    rst = 1'b0;

    // 1: blank until the first boundary, then the snapshot of numbers
    bus.numbers = 32'h12c34c56;
    sync_boundary(n_steps, lit);
    check_eq("first_boundary_cycles", n_steps, 64);
    check_eq("blank_before_first", lit, 1'b0);
    run_frame(-1, 32'h0, -1, 32'h0);
    for (int d = 0; d < 8; d++) check_eq("s1_digit", cap[d], s1_exp[d]);

    // 2: mid-frame numbers change is invisible until the next boundary
    run_frame(-1, 32'h0, 36, 32'h0);
    check_eq("s2_old_d0", cap[0], 8'h7d);
    check_eq("s2_old_d7", cap[7], 8'h06);
    run_frame(-1, 32'h0, -1, 32'h0);
    for (int d = 0; d < 8; d++) check_eq("s2_zero", cap[d], 8'h3f);

    // 3: digits 0-1 blink two frames on, two off
    bus.blink_mask = 8'h03;
    run_frame(-1, 32'h0, -1, 32'h0);
    blank_frames = 0;
    other_blank = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, 32'h0, -1, 32'h0);
      if (cap[0] == 8'h00 && cap[1] == 8'h00) blank_frames++;
      for (int d = 2; d < 8; d++) if (cap[d] == 8'h00) other_blank = 1'b1;
    end
    check_eq("s3_blank_frames", blank_frames, 2);
    check_eq("s3_others_lit", other_blank, 1'b0);
    bus.blink_mask = 8'h00;
    run_frame(-1, 32'h0, -1, 32'h0);

    // 4: overlay shown for exactly three frames
    run_frame(20, 32'hfffffe0d, -1, 32'h0);
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 32'h0, -1, 32'h0);
      check_eq("s4_ov_d0", cap[0], 8'h5e);
      check_eq("s4_ov_d1", cap[1], 8'h3f);
      check_eq("s4_ov_d2", cap[2], 8'h79);
      check_eq("s4_ov_d3", cap[3], 8'h00);
    end
    run_frame(-1, 32'h0, -1, 32'h0);
    check_eq("s4_revert_d0", cap[0], 8'h3f);
    check_eq("s4_revert_ov", bus.overlay_active, 1'b0);

    // 5: mid-frame retrigger and a request coinciding with a boundary
    run_frame(10, 32'hfffffff1, -1, 32'h0);
    for (int f = 0; f < 7; f++) begin
      if (f == 0)      run_frame(30, 32'hfffffff2, -1, 32'h0);
      else if (f == 1) run_frame(63, 32'hfffffff3, -1, 32'h0);
      else             run_frame(-1, 32'h0, -1, 32'h0);
      check_eq("s5_d0", cap[0], s5_exp[f]);
    end

    // 6: reset at digit 5 of an overlay frame discards everything
    bus.overlay_req = 1'b1;
    bus.overlay_numbers = 32'hfffffe0d;
    step();
    bus.overlay_req = 1'b0;
    for (int j = 0; j < 39; j++) step();
    rst = 1'b1;
    step();
    check_eq("s6_seg_en", bus.seg_en, 8'h00);
    check_eq("s6_seg_out", bus.seg_out, 8'h00);
    check_eq("s6_ov", bus.overlay_active, 1'b0);
    check_eq("s6_fd", bus.frame_done, 1'b0);
    rst = 1'b0;
    sync_boundary(n_steps, lit);
    check_eq("s6_first_boundary", n_steps, 64);
    check_eq("s6_blank", lit, 1'b0);
    run_frame(-1, 32'h0, -1, 32'h0);
    check_eq("s6_numbers_d0", cap[0], 8'h3f);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
